// File: rtl/t05_sram_burst_arbiter.sv
// t05_sram_burst_arbiter: arbitrates client burst requests and expands them into single-word wishbone beats.
// Define T05_SRAM_RR_ARB_EN for round-robin arbitration; otherwise the lowest requesting index wins.
module t05_sram_burst_arbiter #(
    parameter int         NUM_CLIENTS = 6,
    parameter int         MAX_WORDS   = 4,
    parameter int         LEN_W       = 3,
    parameter logic [3:0] SEL         = 4'hF
) (
    input  logic                            clk,
    input  logic                            nrst,
    input  logic [NUM_CLIENTS-1:0]          cli_req,
    input  logic [NUM_CLIENTS-1:0]          cli_we,
    input  logic [NUM_CLIENTS*32-1:0]       cli_addr,
    input  logic [NUM_CLIENTS*LEN_W-1:0]    cli_len,
    input  logic [NUM_CLIENTS*MAX_WORDS*32-1:0] cli_wdata,
    output logic [NUM_CLIENTS-1:0]          cli_grant,
    output logic [NUM_CLIENTS-1:0]          cli_done,
    output logic [MAX_WORDS*32-1:0]         cli_rdata,
    output logic                            wr_en,
    output logic                            r_en,
    input  logic                            busy_o,
    output logic [3:0]                      select,
    output logic [31:0]                     addr,
    output logic [31:0]                     data_i,
    input  logic [31:0]                     data_o
);
    localparam int IDX_W  = NUM_CLIENTS > 1 ? $clog2(NUM_CLIENTS) : 1;
    localparam int BEAT_W = MAX_WORDS > 1 ? $clog2(MAX_WORDS) : 1;
    localparam int BUS_W  = MAX_WORDS * 32;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state;
    logic [IDX_W-1:0]  win_c;
    logic [IDX_W-1:0]  win_l;
    logic              we_l;
    logic [31:0]       base_l;
    logic [BUS_W-1:0]  wdata_l;
    logic [BEAT_W-1:0] beat;
    logic [BEAT_W-1:0] beat_nx;
    logic [BEAT_W-1:0] last_l;
    logic [BEAT_W-1:0] last_c;
    logic [LEN_W-1:0]  len_c;
    logic [LEN_W-1:0]  len_sat;

`ifdef T05_SRAM_RR_ARB_EN
    // ptr holds the first index to search, i.e. last winner + 1
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] rr_idx;
    logic             found;
    always_comb begin
        win_c  = '0;
        found  = 1'b0;
        rr_idx = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            rr_idx = IDX_W'((int'(ptr) + i) % NUM_CLIENTS);
            if (!found && cli_req[rr_idx]) begin
                win_c = rr_idx;
                found = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            ptr <= '0;
        else if (state == IDLE && |cli_req)
            ptr <= (int'(win_c) == NUM_CLIENTS - 1) ? '0 : win_c + 1'b1;
    end
`else
    always_comb begin
        win_c = '0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--)
            if (cli_req[IDX_W'(i)]) win_c = IDX_W'(i);
    end
`endif

    // zero-length bursts become one word, oversize ones clamp to MAX_WORDS
    assign len_c   = cli_len[win_c*LEN_W +: LEN_W];
    assign len_sat = len_c == '0 ? LEN_W'(1) : len_c > LEN_W'(MAX_WORDS) ? LEN_W'(MAX_WORDS) : len_c;
    assign last_c  = BEAT_W'(len_sat - 1'b1);
    assign beat_nx = beat + 1'b1;

    assign cli_grant = state == IDLE ? '0 : NUM_CLIENTS'(1) << win_l;
    assign cli_done  = state == DONE ? NUM_CLIENTS'(1) << win_l : '0;
    assign r_en      = state == ISSUE && !we_l;
    assign wr_en     = state == ISSUE && we_l;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            win_l     <= '0;
            we_l      <= 1'b0;
            base_l    <= '0;
            wdata_l   <= '0;
            beat      <= '0;
            last_l    <= '0;
            cli_rdata <= '0;
            addr      <= '0;
            data_i    <= '0;
            select    <= '0;
        end else begin
            case (state)
                IDLE: if (|cli_req) begin
                    win_l   <= win_c;
                    we_l    <= cli_we[win_c];
                    base_l  <= cli_addr[win_c*32 +: 32];
                    wdata_l <= cli_wdata[win_c*BUS_W +: BUS_W];
                    last_l  <= last_c;
                    beat    <= '0;
                    addr    <= cli_addr[win_c*32 +: 32];
                    data_i  <= cli_wdata[win_c*BUS_W +: 32];
                    select  <= SEL;
                    state   <= ISSUE;
                end
                ISSUE: state <= WAIT;
                WAIT: if (!busy_o) begin
                    if (!we_l) cli_rdata[beat*32 +: 32] <= data_o;
                    if (beat == last_l) begin
                        state <= DONE;
                    end else begin
                        beat   <= beat_nx;
                        addr   <= base_l + (32'(beat_nx) << 2);
                        data_i <= wdata_l[beat_nx*32 +: 32];
                        state  <= ISSUE;
                    end
                end
                DONE: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_t05_sram_burst_arbiter.sv
// tb_t05_sram_burst_arbiter: directed vector bench for the SRAM burst arbiter.
// Expected results follow the default fixed-priority build unless T05_SRAM_RR_ARB_EN is defined.
module tb_t05_sram_burst_arbiter;
    localparam int NC = 6;
    localparam int MW = 4;
    localparam int LW = 3;

    logic              clk = 1'b0;
    logic              nrst = 1'b0;
    logic [NC-1:0]     cli_req = '0;
    logic [NC-1:0]     cli_we = '0;
    logic [NC*32-1:0]  cli_addr = '0;
    logic [NC*LW-1:0]  cli_len = '0;
    logic [NC*MW*32-1:0] cli_wdata = '0;
    logic [NC-1:0]     cli_grant;
    logic [NC-1:0]     cli_done;
    logic [MW*32-1:0]  cli_rdata;
    logic              wr_en;
    logic              r_en;
    logic              busy_o;
    logic [3:0]        select;
    logic [31:0]       addr;
    logic [31:0]       data_i;
    logic [31:0]       data_o;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int cyc_set = 0;
    int bcnt = 0;
    int busy_len = 0;

    bit          mon_en = 1'b0;
    int          nbeats = 0;
    int          ndone = 0;
    int          bad_strobe = 0;
    int          done_cyc = 0;
    logic        exp_we = 1'b0;
    logic [31:0] fa = '0;
    logic [31:0] la = '0;
    logic [31:0] fd = '0;
    logic [31:0] ld = '0;
    logic [NC-1:0] g_at = '0;
    logic [NC-1:0] done_vec = '0;

    typedef struct {
        int           cli;
        logic         we;
        logic [31:0]  a;
        logic [2:0]   len;
        int           busy;
        logic [127:0] wd;
        int           mut;
        int           beats;
        logic [31:0]  a0;
        logic [31:0]  al;
        logic [31:0]  d0;
        logic [31:0]  dl;
        int           lat;
        logic [127:0] rd;
    } vec_t;

    vec_t tbl[7];
    vec_t rv;

    t05_sram_burst_arbiter dut (
        .clk(clk), .nrst(nrst), .cli_req(cli_req), .cli_we(cli_we), .cli_addr(cli_addr),
        .cli_len(cli_len), .cli_wdata(cli_wdata), .cli_grant(cli_grant), .cli_done(cli_done),
        .cli_rdata(cli_rdata), .wr_en(wr_en), .r_en(r_en), .busy_o(busy_o), .select(select),
        .addr(addr), .data_i(data_i), .data_o(data_o)
    );

    always #5 clk = ~clk;

    // wishbone slave model: busy for busy_len cycles after each strobe, read data derived from addr
    always @(posedge clk) begin
        cyc  <= cyc + 1;
        bcnt <= (r_en || wr_en) ? busy_len : (bcnt > 0 ? bcnt - 1 : 0);
    end
    assign busy_o = bcnt > 0;
    assign data_o = 32'hD000_0000 ^ addr;

    always @(negedge clk) begin
        if (mon_en) begin
            if (r_en || wr_en) begin
                if (nbeats == 0) begin
                    fa   = addr;
                    fd   = data_i;
                    g_at = cli_grant;
                end
                la = addr;
                ld = data_i;
                nbeats++;
                if ((r_en && wr_en) || wr_en != exp_we || select != 4'hF) bad_strobe++;
            end
            if (|cli_done) begin
                ndone++;
                done_vec = cli_done;
                done_cyc = cyc;
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic start(input vec_t v);
        @(negedge clk);
        cli_req    = '0;
        busy_len   = v.busy;
        exp_we     = v.we;
        nbeats     = 0;
        ndone      = 0;
        bad_strobe = 0;
        done_cyc   = 0;
        mon_en     = 1'b1;
        cli_we[v.cli]              = v.we;
        cli_addr[v.cli*32 +: 32]   = v.a;
        cli_len[v.cli*LW +: LW]    = v.len;
        cli_wdata[v.cli*128 +: 128] = v.wd;
        cli_req[v.cli]             = 1'b1;
        cyc_set = cyc;
    endtask

    task automatic wait_beats(input string tag, input int n);
        for (int k = 0; k < 200 && nbeats < n; k++) begin
            @(negedge clk);
            #1;
        end
        chk({tag, " beat wait"}, 128'(nbeats >= n), 128'(1));
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        start(v);
        if (v.mut > 0) begin
            wait_beats(tag, v.mut);
            cli_addr[v.cli*32 +: 32] = 32'h900;
            cli_req[v.cli] = 1'b0;
        end
        for (int k = 0; k < 300 && ndone == 0; k++) begin
            @(negedge clk);
            #1;
        end
        cli_req[v.cli] = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        mon_en = 1'b0;
        chk({tag, " beats"}, 128'(nbeats), 128'(v.beats));
        chk({tag, " first addr"}, 128'(fa), 128'(v.a0));
        chk({tag, " last addr"}, 128'(la), 128'(v.al));
        chk({tag, " first data_i"}, 128'(fd), 128'(v.d0));
        chk({tag, " last data_i"}, 128'(ld), 128'(v.dl));
        chk({tag, " strobe/select"}, 128'(bad_strobe), 128'(0));
        chk({tag, " done count"}, 128'(ndone), 128'(1));
        chk({tag, " done client"}, 128'(done_vec), 128'(NC'(1) << v.cli));
        chk({tag, " grant"}, 128'(g_at), 128'(NC'(1) << v.cli));
        chk({tag, " latency"}, 128'(done_cyc - cyc_set + 1), 128'(v.lat));
        chk({tag, " rdata"}, cli_rdata, v.rd);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NC-1:0] exp_done;
        tbl[0] = '{2, 1'b0, 32'h800, 3'd4, 0, 128'h0, 0, 4, 32'h800, 32'h80C, 32'h0, 32'h0, 10,
                   128'hD000080C_D0000808_D0000804_D0000800};
        tbl[1] = '{1, 1'b1, 32'h400, 3'd2, 3, 128'h00000000_00000000_AAAA0002_AAAA0001, 0, 2,
                   32'h400, 32'h404, 32'hAAAA0001, 32'hAAAA0002, 12,
                   128'hD000080C_D0000808_D0000804_D0000800};
        tbl[2] = '{5, 1'b0, 32'h100, 3'd0, 1, 128'h0, 0, 1, 32'h100, 32'h100, 32'h0, 32'h0, 5,
                   128'hD000080C_D0000808_D0000804_D0000100};
        tbl[3] = '{0, 1'b0, 32'h200, 3'd7, 0, 128'h0, 0, 4, 32'h200, 32'h20C, 32'h0, 32'h0, 10,
                   128'hD000020C_D0000208_D0000204_D0000200};
        tbl[4] = '{3, 1'b1, 32'hFFFFFFFC, 3'd2, 0, 128'h00000000_00000000_BBBB0002_BBBB0001, 0, 2,
                   32'hFFFFFFFC, 32'h0, 32'hBBBB0001, 32'hBBBB0002, 6,
                   128'hD000020C_D0000208_D0000204_D0000200};
        tbl[5] = '{4, 1'b1, 32'h40, 3'd3, 2, 128'h00000000_00000033_00000022_00000011, 0, 3,
                   32'h40, 32'h48, 32'h11, 32'h33, 14,
                   128'hD000020C_D0000208_D0000204_D0000200};
        tbl[6] = '{4, 1'b0, 32'h300, 3'd3, 1, 128'h0, 2, 3, 32'h300, 32'h308, 32'h0, 32'h0, 11,
                   128'hD000020C_D0000308_D0000304_D0000300};

        repeat (3) @(negedge clk);
        chk("reset outputs", 128'({r_en, wr_en, cli_grant, cli_done, select, addr, data_i}), 128'(0));
        chk("reset rdata", cli_rdata, 128'(0));
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle outputs", 128'({r_en, wr_en, cli_grant, cli_done}), 128'(0));

        for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("v%0d", i));

        // asynchronous reset in the WAIT phase of beat 2
        rv = '{2, 1'b0, 32'h500, 3'd4, 2, 128'h0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 128'h0};
        start(rv);
        wait_beats("rst", 3);
        @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        chk("rst mid outputs", 128'({r_en, wr_en, cli_grant, cli_done, select, addr, data_i}), 128'(0));
        chk("rst mid rdata", cli_rdata, 128'(0));
        cli_req = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst no done", 128'(ndone), 128'(0));
        mon_en = 1'b0;
        nrst = 1'b1;
        rv = '{5, 1'b0, 32'h600, 3'd2, 0, 128'h0, 0, 2, 32'h600, 32'h604, 32'h0, 32'h0, 6,
               128'h00000000_00000000_D0000604_D0000600};
        run_vec(rv, "post-rst");

        // contention between clients 0 and 3, both holding req high
        @(negedge clk);
        busy_len = 0;
        cli_we = '0;
        cli_addr[0*32 +: 32] = 32'h10;
        cli_addr[3*32 +: 32] = 32'h30;
        cli_len[0*LW +: LW] = 3'd1;
        cli_len[3*LW +: LW] = 3'd1;
        cli_req = 6'b001001;
        for (int k = 0; k < 4; k++) begin
`ifdef T05_SRAM_RR_ARB_EN
            exp_done = (k % 2 == 1) ? 6'b001000 : 6'b000001;
`else
            exp_done = 6'b000001;
`endif
            for (int t = 0; t < 100 && cli_done == '0; t++) begin
                @(negedge clk);
                #1;
            end
            chk($sformatf("contention %0d", k), 128'(cli_done), 128'(exp_done));
            @(negedge clk);
        end
        cli_req = '0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
